ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single 4096x16 block RAM between two requesters: port A (rcpu) and port B (UART boot loader / DMA).
- Sits between the requesters and ram_memory, and drives its read and write ports.
- Holds off all RAM traffic until the PLL is locked plus a startup delay. This moves the top-level "wait ~40 cycles before touching RAM" workaround into a reusable block.
- Arbitrates per cycle, with a starvation guard for the low-priority port.

Parameters:
- STARTUP_CYCLES, 41: cycles with pll_lock=1 that must elapse before the first grant.
- MAX_WAIT, 8: consecutive cycles port B may be denied before it is force-granted.
- AW, 16: address width passed through to RAM.

Ports:
- clk  in  1  system clock (PLL output).
- resetq  in  1  synchronous reset, active-low.
- pll_lock  in  1  PLL lock indicator.
- started  out  1  high once the startup delay has completed.
- a_req  in  1  port A transaction request; held until accepted.
- a_we  in  1  1=write, 0=read.
- a_addr  in  AW  port A address.
- a_wdata  in  16  port A write data.
- a_ready  out  1  port A accept; a transaction completes when a_req&a_ready.
- a_rdata  out  16  port A read data.
- a_rvalid  out  1  port A read data valid, one cycle pulse.
- b_req, b_we, b_addr, b_wdata, b_ready, b_rdata, b_rvalid: same as the port A signals, for port B.
- mem_read_enable  out  1  to RAM.
- mem_write_enable  out  1  to RAM.
- mem_read_address  out  AW  to RAM.
- mem_write_address  out  AW  to RAM.
- mem_write_data  out  16  to RAM.
- mem_read_data  in  16  from RAM, registered, 1-cycle latency.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on resetq; all state clears on the first rising edge of clk with resetq=0.
- Reset values: started=0, a_ready=b_ready=0, a_rvalid=b_rvalid=0, startup counter=0, wait counter=0, RR pointer=A, read-owner flags=0. The mem_* enables are 0 in every cycle where no grant is issued.
- State machine STARTUP:
  - Counter increments each cycle while pll_lock=1 and holds while pll_lock=0.
  - When the counter equals STARTUP_CYCLES-1 and pll_lock=1, go to RUN next cycle and set started=1.
  - No grants are issued in STARTUP.
- State machine RUN:
  - Absorbing; left only by reset.
  - pll_lock dropping in RUN has no effect.
- Grant: combinational in RUN, at most one port per cycle.
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant A, unless the wait counter == MAX_WAIT, in which case grant B.
- Wait counter:
  - Increments when b_req=1 and B is not granted, saturating at MAX_WAIT.
  - Clears when B is granted or b_req=0.
- RAM drive for the granted port:
  - Write: mem_write_enable=1, with address and data taken from that port, in the same cycle.
  - Read: mem_read_enable=1 and mem_read_address=port address.
  - Ungranted cycles: enables 0, and addresses/data hold the last values (no toggling).
- Read return:
  - An accepted read sets an owner flag registered for one cycle.
  - Next cycle, the owner's x_rvalid=1 and x_rdata=mem_read_data.
  - Back-to-back reads give one rvalid per accept with no bubbles.
  - rdata of the non-owner port holds its previous value.
- Addresses are passed unmodified; wrap above 4095 is the RAM's concern.
- Write then read of the same address in consecutive grants returns the new data.
- Reset asserted while a read is in flight: the rvalid pulse is suppressed, and there is no return after reset.

Optional Feature:
- RAM_ARB_RR_EN defined: round-robin arbitration.
  - When both ports request, grant the port opposite the last-granted port.
  - The RR pointer updates on every grant.
  - MAX_WAIT and the wait counter are unused (counter held at 0).
- Not defined: fixed A priority with the MAX_WAIT starvation guard, as described under Behaviour.

Decomposition:
- Shared package rcpu_pkg holds:
  - localparam RAM_WORDS=4096 and the 16-bit word width.
  - The startup default of 41.
  - The owner encoding constants OWN_NONE, OWN_A, OWN_B.
- One natural sub-module, startup_delay: the counter plus pll_lock gating, producing started. It is reusable for other RAM-touching IP.
- Arbitration and the datapath mux stay in ram_arbiter.

Test Plan:
- Startup:
  - pll_lock=0 for 20 cycles, then 1, with a_req=1 read held throughout.
  - Required: a_ready=0 until exactly 41 lock cycles have elapsed; started rises on the same edge; the first grant and mem_read_enable follow the same cycle.
- Contention:
  - a_req and b_req held high in RUN with MAX_WAIT=8.
  - Required: A granted 8 consecutive cycles, B granted on the 9th, then the pattern repeats.
  - With RAM_ARB_RR_EN defined: strict A,B,A,B alternation.
- Read/write ordering:
  - A writes 0xBEEF to 0x0010, then B reads 0x0010 the next cycle.
  - Required: b_rvalid=1 one cycle after the B grant, with b_rdata=0xBEEF; a_rvalid stays 0.
- Streaming:
  - A issues 5 back-to-back reads of addresses 0..4, preloaded with 0x1000..0x1004.
  - Required: a_rvalid high for 5 consecutive cycles, with data 0x1000..0x1004 in order.
- Reset mid-read:
  - B read accepted, then resetq=0 on the next edge.
  - Required: no b_rvalid pulse; started=0; the STARTUP count restarts from 0.
- Address wrap:
  - A writes 0x5A5A to 0x1005.
  - Required: mem_write_address=0x1005 unmodified, and a readback of 0x0005 returns 0x5A5A.

Source files
------------

// File: rtl/rcpu_pkg.sv
// Shared constants and types for the rcpu RAM subsystem: RAM geometry, startup default,
// read-owner encoding and the startup FSM state type.
package rcpu_pkg;

  localparam int unsigned RAM_WORDS       = 4096;
  localparam int unsigned WORD_W          = 16;
  localparam int unsigned STARTUP_DEFAULT = 41;

  typedef logic [WORD_W-1:0] word_t;

  // Which port owns the read data returning from the RAM this cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  typedef enum logic {
    StStartup,
    StRun
  } startup_state_e;

endpackage

// File: rtl/startup_delay.sv
// Holds off RAM traffic until pll_lock has been high for STARTUP_CYCLES cycles; then latches
// started until the next reset. STARTUP_CYCLES must be at least 1.
module startup_delay
  import rcpu_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = STARTUP_DEFAULT
) (
  input  logic clk,
  input  logic resetq,
  input  logic pll_lock,
  output logic started
);

  localparam int unsigned CntW = $clog2(STARTUP_CYCLES + 1);

  startup_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StStartup: begin
        // Lock cycles need not be contiguous: the count only pauses while unlocked.
        if (pll_lock) begin
          if (cnt_q == CntW'(STARTUP_CYCLES - 1)) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRun: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q <= StStartup;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign started = (state_q == StRun);

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the shared 4096x16 block RAM, gated by startup_delay.
// Define RAM_ARB_RR_EN for round-robin; otherwise A has priority with a MAX_WAIT guard for B.
module ram_arbiter
  import rcpu_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = STARTUP_DEFAULT,
  parameter int unsigned MAX_WAIT       = 8,
  parameter int unsigned AW             = 16
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          pll_lock,
  output logic          started,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  word_t         a_wdata,
  output logic          a_ready,
  output word_t         a_rdata,
  output logic          a_rvalid,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  word_t         b_wdata,
  output logic          b_ready,
  output word_t         b_rdata,
  output logic          b_rvalid,

  output logic          mem_read_enable,
  output logic          mem_write_enable,
  output logic [AW-1:0] mem_read_address,
  output logic [AW-1:0] mem_write_address,
  output word_t         mem_write_data,
  input  word_t         mem_read_data
);

  logic run;
  logic gnt_a, gnt_b, gnt;
  logic pick_b;

  startup_delay #(
    .STARTUP_CYCLES(STARTUP_CYCLES)
  ) u_startup (
    .clk     (clk),
    .resetq  (resetq),
    .pll_lock(pll_lock),
    .started (started)
  );

  // Gating with resetq keeps the cycle in which reset is being applied completely quiet.
  assign run = started & resetq;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (run) begin
      if (a_req && b_req) begin
        gnt_b = pick_b;
        gnt_a = ~pick_b;
      end else begin
        gnt_a = a_req;
        gnt_b = b_req;
      end
    end
  end

`ifdef RAM_ARB_RR_EN
  // Remembers the last granted port; the wait counter is not needed in this mode.
  logic last_b_q, last_b_d;

  assign pick_b = ~last_b_q;

  always_comb begin
    last_b_d = last_b_q;
    if (gnt_a) begin
      last_b_d = 1'b0;
    end else if (gnt_b) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      last_b_q <= 1'b0;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [WaitW-1:0] wait_q, wait_d;

  // A saturated counter both forces the B grant and stops counting.
  assign pick_b = (wait_q == WaitW'(MAX_WAIT));

  always_comb begin
    wait_d = '0;
    if (b_req && !gnt_b) begin
      wait_d = pick_b ? wait_q : wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  word_t         sel_wdata;
  logic [AW-1:0] raddr_q, waddr_q;
  word_t         wdata_q;
  logic [1:0]    owner_q, owner_d;
  word_t         a_rdata_q, b_rdata_q;

  assign gnt       = gnt_a | gnt_b;
  assign sel_we    = gnt_b ? b_we    : a_we;
  assign sel_addr  = gnt_b ? b_addr  : a_addr;
  assign sel_wdata = gnt_b ? b_wdata : a_wdata;

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  assign mem_write_enable  = gnt & sel_we;
  assign mem_read_enable   = gnt & ~sel_we;
  // Address and data buses hold their last value on idle cycles to avoid needless toggling.
  assign mem_write_address = mem_write_enable ? sel_addr  : waddr_q;
  assign mem_write_data    = mem_write_enable ? sel_wdata : wdata_q;
  assign mem_read_address  = mem_read_enable  ? sel_addr  : raddr_q;

  always_comb begin
    owner_d = OWN_NONE;
    if (mem_read_enable) begin
      owner_d = gnt_b ? OWN_B : OWN_A;
    end
  end

  assign a_rvalid = resetq & (owner_q == OWN_A);
  assign b_rvalid = resetq & (owner_q == OWN_B);
  assign a_rdata  = a_rvalid ? mem_read_data : a_rdata_q;
  assign b_rdata  = b_rvalid ? mem_read_data : b_rdata_q;

  always_ff @(posedge clk) begin
    if (!resetq) begin
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      owner_q   <= OWN_NONE;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      raddr_q   <= mem_read_address;
      waddr_q   <= mem_write_address;
      wdata_q   <= mem_write_data;
      owner_q   <= owner_d;
      a_rdata_q <= a_rdata;
      b_rdata_q <= b_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic, compared each
// cycle against a transaction-level reference model and a simple RAM stand-in.
module tb_ram_arbiter;

  localparam int STARTUP = 41;
  localparam int MAXW    = 8;

  logic        clk = 1'b0;
  logic        resetq, pll_lock, started;
  logic        a_req, a_we, a_ready, a_rvalid;
  logic        b_req, b_we, b_ready, b_rvalid;
  logic [15:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [15:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  ram_arbiter #(
    .STARTUP_CYCLES(STARTUP),
    .MAX_WAIT      (MAXW),
    .AW            (16)
  ) dut (
    .clk              (clk),
    .resetq           (resetq),
    .pll_lock         (pll_lock),
    .started          (started),
    .a_req            (a_req),
    .a_we             (a_we),
    .a_addr           (a_addr),
    .a_wdata          (a_wdata),
    .a_ready          (a_ready),
    .a_rdata          (a_rdata),
    .a_rvalid         (a_rvalid),
    .b_req            (b_req),
    .b_we             (b_we),
    .b_addr           (b_addr),
    .b_wdata          (b_wdata),
    .b_ready          (b_ready),
    .b_rdata          (b_rdata),
    .b_rvalid         (b_rvalid),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_read_address (mem_read_address),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  function automatic logic [15:0] preload(input logic [11:0] a);
    return 16'h1000 + {4'h0, a};
  endfunction

  // RAM stand-in: 4096 words, registered read, unwritten words return the preload pattern.
  logic [15:0] ram [4096];
  bit          written [4096];
  always @(posedge clk) begin
    if (mem_write_enable === 1'b1) begin
      ram[mem_write_address[11:0]]     <= mem_write_data;
      written[mem_write_address[11:0]] <= 1'b1;
    end
    if (mem_read_enable === 1'b1) begin
      mem_read_data <= written[mem_read_address[11:0]] ? ram[mem_read_address[11:0]]
                                                       : preload(mem_read_address[11:0]);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  int          m_count, m_wait, m_owner, m_last;
  bit          m_started;
  logic [15:0] m_pend, m_ahold, m_bhold, m_waddr, m_wdata, m_raddr;
  logic [15:0] ref_mem [4096];

  task automatic reset_model();
    m_count = 0; m_wait = 0; m_owner = 0; m_last = 1; m_started = 0;
    m_pend = '0; m_ahold = '0; m_bhold = '0; m_waddr = '0; m_wdata = '0; m_raddr = '0;
  endtask

  // One clock cycle: check outputs against the model, then advance the model at the edge.
  task automatic tick();
    int          g;
    bit          run, gwe, we_e, re_e, arv, brv;
    logic [15:0] gaddr, gdata;
    #1;
    run = m_started && resetq;
    g   = 0;
    if (run) begin
      if (a_req && b_req) begin
`ifdef RAM_ARB_RR_EN
        g = (m_last == 1) ? 2 : 1;
`else
        g = (m_wait == MAXW) ? 2 : 1;
`endif
      end else if (a_req) begin
        g = 1;
      end else if (b_req) begin
        g = 2;
      end
    end
    gwe   = (g == 2) ? b_we    : a_we;
    gaddr = (g == 2) ? b_addr  : a_addr;
    gdata = (g == 2) ? b_wdata : a_wdata;
    we_e  = (g != 0) && gwe;
    re_e  = (g != 0) && !gwe;
    arv   = resetq && (m_owner == 1);
    brv   = resetq && (m_owner == 2);
    chk("started", started, m_started);
    chk("a_ready", a_ready, g == 1);
    chk("b_ready", b_ready, g == 2);
    chk("mem_write_enable", mem_write_enable, we_e);
    chk("mem_read_enable", mem_read_enable, re_e);
    chk("mem_write_address", mem_write_address, we_e ? gaddr : m_waddr);
    chk("mem_write_data", mem_write_data, we_e ? gdata : m_wdata);
    chk("mem_read_address", mem_read_address, re_e ? gaddr : m_raddr);
    chk("a_rvalid", a_rvalid, arv);
    chk("a_rdata", a_rdata, arv ? m_pend : m_ahold);
    chk("b_rvalid", b_rvalid, brv);
    chk("b_rdata", b_rdata, brv ? m_pend : m_bhold);
    @(posedge clk);
    if (!resetq) begin
      reset_model();
    end else begin
      if (!m_started && pll_lock) begin
        if (m_count == STARTUP - 1) m_started = 1;
        else m_count++;
      end
      if (m_owner == 1) m_ahold = m_pend;
      if (m_owner == 2) m_bhold = m_pend;
`ifdef RAM_ARB_RR_EN
      m_wait = 0;
`else
      if (b_req && g != 2) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
      else m_wait = 0;
`endif
      if (g != 0) m_last = g;
      m_owner = 0;
      if (we_e) begin
        ref_mem[gaddr[11:0]] = gdata;
        m_waddr = gaddr;
        m_wdata = gdata;
      end
      if (re_e) begin
        m_owner = g;
        m_pend  = ref_mem[gaddr[11:0]];
        m_raddr = gaddr;
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit exp_a;
    for (int i = 0; i < 4096; i++) ref_mem[i] = preload(12'(i));
    reset_model();
    resetq = 1'b0; pll_lock = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    @(posedge clk);
    #1;
    tick();
    tick();

    // Startup: 20 unlocked cycles, then count lock cycles until the first grant.
    resetq = 1'b1;
    a_req  = 1'b1;
    repeat (20) tick();
    pll_lock = 1'b1;
    n = 0;
    while (a_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("startup_lock_cycles", n, STARTUP);
    chk("startup_started", started, 1);
    chk("startup_first_read", mem_read_enable, 1);

    // Contention: both read continuously.
    b_req = 1'b1;
    for (int k = 0; k < 27; k++) begin
      a_addr = 16'($urandom_range(0, 4095));
      b_addr = 16'($urandom_range(0, 4095));
`ifdef RAM_ARB_RR_EN
      exp_a = (k % 2) == 1;
`else
      exp_a = (k % 9) != 8;
`endif
      #1;
      chk($sformatf("contend_a_ready_%0d", k), a_ready, exp_a);
      chk($sformatf("contend_b_ready_%0d", k), b_ready, !exp_a);
      tick();
    end

    // Write by A, then read of the same word by B.
    b_req = 1'b0;
    a_we = 1'b1; a_addr = 16'h0010; a_wdata = 16'hBEEF;
    tick();
    a_req = 1'b0; a_we = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0010;
    #1;
    chk("rw_b_granted", b_ready, 1);
    tick();
    b_req = 1'b0;
    #1;
    chk("rw_b_rvalid", b_rvalid, 1);
    chk("rw_b_rdata", b_rdata, 16'hBEEF);
    chk("rw_a_rvalid", a_rvalid, 0);
    tick();

    // Streaming: five back-to-back reads of 0..4.
    for (int i = 0; i < 6; i++) begin
      a_req  = (i < 5);
      a_addr = 16'(i);
      #1;
      if (i > 0) begin
        chk($sformatf("stream_rvalid_%0d", i - 1), a_rvalid, 1);
        chk($sformatf("stream_rdata_%0d", i - 1), a_rdata, 16'h1000 + 16'(i - 1));
      end
      tick();
    end
    chk("stream_end_rvalid", a_rvalid, 0);

    // Address passthrough above 4095.
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h1005; a_wdata = 16'h5A5A;
    #1;
    chk("wrap_we", mem_write_enable, 1);
    chk("wrap_waddr", mem_write_address, 16'h1005);
    tick();
    a_we = 1'b0; a_addr = 16'h0005;
    tick();
    a_req = 1'b0;
    #1;
    chk("wrap_rvalid", a_rvalid, 1);
    chk("wrap_rdata", a_rdata, 16'h5A5A);
    tick();

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      a_req   = ($urandom_range(0, 3) != 0);
      b_req   = ($urandom_range(0, 3) != 0);
      a_we    = $urandom_range(0, 1) == 1;
      b_we    = $urandom_range(0, 1) == 1;
      a_addr  = 16'(($urandom_range(0, 15) << 12) | $urandom_range(0, 31));
      b_addr  = 16'(($urandom_range(0, 15) << 12) | $urandom_range(0, 31));
      a_wdata = 16'($urandom);
      b_wdata = 16'($urandom);
      tick();
    end

    // Reset while a B read is in flight.
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0020;
    #1;
    chk("rst_b_granted", b_ready, 1);
    tick();
    b_req  = 1'b0;
    resetq = 1'b0;
    #1;
    chk("rst_no_rvalid", b_rvalid, 0);
    tick();
    chk("rst_started_low", started, 0);
    resetq = 1'b1;
    n = 0;
    while (started !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_restart_cycles", n, STARTUP);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
